// File: rtl/patp_pkg.sv
// ---------------------------------------------------------------------------
// patp_pkg
//   Shared constants for the PATP core control path.
//   - Opcode encodings carried in IR[7:5].
//   - ALU function select encodings driven by the control sequencer.
//   - Control sequencer state encoding.
//   - Small opcode classification helpers used by the sequencer decode.
// ---------------------------------------------------------------------------
package patp_pkg;

    // Opcodes (IR[7:5])
    localparam logic [2:0] OP_STOP  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_JMP   = 3'b101;
    localparam logic [2:0] OP_JGE   = 3'b110;
    localparam logic [2:0] OP_JNE   = 3'b111;

    // ALU function select
    localparam logic [1:0] ALU_PASS = 2'b00;  // result = MBR
    localparam logic [1:0] ALU_ADD  = 2'b01;  // result = acc + MBR
    localparam logic [1:0] ALU_SUB  = 2'b10;  // result = acc - MBR

    // Sequencer states. Codes 9..15 are unused and recover to IDLE.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH0 = 4'd1,
        ST_FETCH1 = 4'd2,
        ST_FETCH2 = 4'd3,
        ST_DECODE = 4'd4,
        ST_EXEC0  = 4'd5,
        ST_EXEC1  = 4'd6,
        ST_EXEC2  = 4'd7,
        ST_HALT   = 4'd8
    } seq_state_e;

    // Opcodes that finish in DECODE and go straight back to fetch.
    function automatic logic is_jump(input logic [2:0] op);
        return (op == OP_JMP) || (op == OP_JGE) || (op == OP_JNE);
    endfunction

    // ALU function for the accumulator-writing opcodes. Anything else
    // falls back to PASS; EXEC2 is only reached by LOAD/ADD/SUB.
    function automatic logic [1:0] alu_for_op(input logic [2:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Fetch/decode/execute FSM for the PATP core. Produces one-cycle enable
//   pulses that the datapath samples on the next rising clk.
//
//   Ports
//     clk, rst      clock; asynchronous active-high reset (forces IDLE)
//     run           level, sampled only in IDLE to start fetching
//     ir_opcode     IR[7:5], stable from DECODE to end of instruction
//     acc_z, acc_n  accumulator zero / negative flags, used only in DECODE
//     clk_mar       MAR load enable
//     mar_sel       MAR source: 0 = PC, 1 = IR[4:0]
//     pc_inc        PC <= PC + 1
//     pc_load       PC <= IR[4:0]
//     clk_ir        IR <= MBR
//     clk_mbr       MBR <= memory data
//     mem_rd        memory read strobe
//     mem_wr        memory write strobe (data = accumulator)
//     clk_acc       accumulator <= ALU result
//     alu_op        ALU function select (see patp_pkg)
//     halted        high in HALT
//
//   Handshake: there is none; every enable is a single-cycle pulse decoded
//   from the registered state, and the datapath acts on it at the next edge.
//   Outputs are combinational from state_q (plus opcode/flags), so an async
//   reset drops every enable, including mem_wr, at the instant it asserts.
// ---------------------------------------------------------------------------
module control_sequencer
    import patp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] ir_opcode,
    input  logic       acc_z,
    input  logic       acc_n,
    output logic       clk_mar,
    output logic       mar_sel,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       clk_ir,
    output logic       clk_mbr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       clk_acc,
    output logic [1:0] alu_op,
    output logic       halted
);

    seq_state_e state_q;
    seq_state_e state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        clk_mar = 1'b0;
        mar_sel = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        clk_ir  = 1'b0;
        clk_mbr = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        clk_acc = 1'b0;
        alu_op  = ALU_PASS;
        halted  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH0;
                end
            end
            ST_FETCH0: begin
                clk_mar = 1'b1;           // MAR <= PC
                state_d = ST_FETCH1;
            end
            ST_FETCH1: begin
                mem_rd  = 1'b1;
                clk_mbr = 1'b1;
                pc_inc  = 1'b1;
                state_d = ST_FETCH2;
            end
            ST_FETCH2: begin
                clk_ir  = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (ir_opcode == OP_STOP) begin
                    state_d = ST_HALT;
                end else if (is_jump(ir_opcode)) begin
                    // Conditional jumps look at the flags left by the
                    // previous instruction's EXEC2.
                    case (ir_opcode)
                        OP_JGE:  pc_load = ~acc_n;
                        OP_JNE:  pc_load = ~acc_z;
                        default: pc_load = 1'b1;
                    endcase
                    state_d = ST_FETCH0;
                end else begin
                    state_d = ST_EXEC0;
                end
            end
            ST_EXEC0: begin
                clk_mar = 1'b1;           // MAR <= IR[4:0]
                mar_sel = 1'b1;
                state_d = ST_EXEC1;
            end
            ST_EXEC1: begin
                if (ir_opcode == OP_STORE) begin
                    mem_wr  = 1'b1;
                    state_d = ST_FETCH0;
                end else begin
                    mem_rd  = 1'b1;
                    clk_mbr = 1'b1;
                    state_d = ST_EXEC2;
                end
            end
            ST_EXEC2: begin
                clk_acc = 1'b1;
                alu_op  = alu_for_op(ir_opcode);
                state_d = ST_FETCH0;
            end
            ST_HALT: begin
                halted  = 1'b1;           // only rst leaves HALT
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//   Directed bench for control_sequencer. Outputs are packed into one
//   12-bit word per cycle and compared against hand-computed words held in
//   an expected queue.
//   Word layout:
//     [11] clk_mar [10] mar_sel [9] pc_inc [8] pc_load [7] clk_ir
//     [6] clk_mbr  [5] mem_rd   [4] mem_wr [3] clk_acc [2:1] alu_op [0] halted
//   Inputs change at the falling edge and outputs are sampled 1ns later.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    localparam int W = 12;

    // Hand-computed per-state output words
    localparam logic [W-1:0] V_NONE  = 12'h000;
    localparam logic [W-1:0] V_F0    = 12'h800; // clk_mar, sel 0
    localparam logic [W-1:0] V_F1    = 12'h260; // pc_inc, clk_mbr, mem_rd
    localparam logic [W-1:0] V_F2    = 12'h080; // clk_ir
    localparam logic [W-1:0] V_JUMP  = 12'h100; // pc_load
    localparam logic [W-1:0] V_E0    = 12'hC00; // clk_mar, sel 1
    localparam logic [W-1:0] V_E1RD  = 12'h060; // clk_mbr, mem_rd
    localparam logic [W-1:0] V_E1WR  = 12'h010; // mem_wr
    localparam logic [W-1:0] V_E2PAS = 12'h008; // clk_acc, alu 00
    localparam logic [W-1:0] V_E2ADD = 12'h00A; // clk_acc, alu 01
    localparam logic [W-1:0] V_E2SUB = 12'h00C; // clk_acc, alu 10
    localparam logic [W-1:0] V_HALT  = 12'h001; // halted

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [2:0] ir_opcode = 3'b000;
    logic       acc_z = 1'b0;
    logic       acc_n = 1'b0;

    always #5 clk = ~clk;

    logic       clk_mar, mar_sel, pc_inc, pc_load, clk_ir, clk_mbr;
    logic       mem_rd, mem_wr, clk_acc, halted;
    logic [1:0] alu_op;

    control_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .ir_opcode (ir_opcode),
        .acc_z     (acc_z),
        .acc_n     (acc_n),
        .clk_mar   (clk_mar),
        .mar_sel   (mar_sel),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .clk_ir    (clk_ir),
        .clk_mbr   (clk_mbr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .clk_acc   (clk_acc),
        .alu_op    (alu_op),
        .halted    (halted)
    );

    logic [W-1:0] outs;
    assign outs = {clk_mar, mar_sel, pc_inc, pc_load, clk_ir, clk_mbr,
                   mem_rd, mem_wr, clk_acc, alu_op, halted};

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] obs,
                            input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %03h expected %03h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Hold inputs for one cycle and compare the sampled outputs against the
    // next expected word.
    task automatic step_check(input string tag, input logic [2:0] op,
                              input logic z, input logic n);
        logic [W-1:0] exp;
        @(negedge clk);
        ir_opcode = op;
        acc_z     = z;
        acc_n     = n;
        #1;
        if (exp_q.size() == 0) begin
            exp = 'x;
            n_checks++;
            n_fails++;
            $display("FAIL %s: expected queue empty", tag);
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, outs, exp);
        end
    endtask

    // Load the expected words for one full instruction starting in FETCH0.
    task automatic expect_instr(input logic [2:0] op, input logic z,
                                input logic n);
        exp_q.push_back(V_F0);
        exp_q.push_back(V_F1);
        exp_q.push_back(V_F2);
        case (op)
            3'b000: exp_q.push_back(V_NONE);                         // STOP
            3'b101: exp_q.push_back(V_JUMP);                         // JMP
            3'b110: exp_q.push_back(n ? V_NONE : V_JUMP);            // JGE
            3'b111: exp_q.push_back(z ? V_NONE : V_JUMP);            // JNE
            3'b010: begin                                            // STORE
                exp_q.push_back(V_NONE);
                exp_q.push_back(V_E0);
                exp_q.push_back(V_E1WR);
            end
            default: begin                                           // LOAD/ADD/SUB
                exp_q.push_back(V_NONE);
                exp_q.push_back(V_E0);
                exp_q.push_back(V_E1RD);
                exp_q.push_back(op == 3'b001 ? V_E2PAS :
                                op == 3'b011 ? V_E2ADD : V_E2SUB);
            end
        endcase
    endtask

    task automatic do_instr(input string tag, input logic [2:0] op,
                            input logic z, input logic n);
        int len;
        expect_instr(op, z, n);
        len = exp_q.size();
        for (int i = 0; i < len; i++) begin
            step_check($sformatf("%s_c%0d", tag, i), op, z, n);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset held: all outputs low
        #2;
        check_eq("reset_outs", outs, V_NONE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // run low for 10 cycles: stays IDLE
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(V_NONE);
            step_check($sformatf("idle_c%0d", i), 3'b001, 1'b0, 1'b0);
        end

        // Raise run; first cycle after it is sampled is FETCH0
        @(negedge clk);
        run = 1'b1;

        do_instr("load",  3'b001, 1'b0, 1'b0);
        run = 1'b0;  // no effect once running
        do_instr("add",   3'b011, 1'b1, 1'b1);
        do_instr("sub",   3'b100, 1'b0, 1'b1);
        do_instr("store", 3'b010, 1'b0, 1'b0);
        do_instr("jmp",   3'b101, 1'b1, 1'b1);
        do_instr("jge_n1", 3'b110, 1'b0, 1'b1);
        do_instr("jge_n0", 3'b110, 1'b1, 1'b0);
        do_instr("jne_z1", 3'b111, 1'b1, 1'b0);
        do_instr("jne_z0", 3'b111, 1'b0, 1'b1);
        do_instr("stop",  3'b000, 1'b0, 1'b0);

        // HALT from the fifth cycle on, immune to run
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(V_HALT);
            run = i[0];
            step_check($sformatf("halt_c%0d", i), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset from HALT returns to IDLE
        @(negedge clk);
        run = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("halt_rst", outs, V_NONE);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(V_NONE);
            step_check($sformatf("post_halt_idle_c%0d", i), 3'b010, 1'b0, 1'b0);
        end

        // Start a STORE and reset asynchronously during EXEC1
        @(negedge clk);
        run = 1'b1;
        expect_instr(3'b010, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step_check($sformatf("store2_c%0d", i), 3'b010, 1'b0, 1'b0);
        end
        // Last step left us in EXEC1 with mem_wr high; hit rst mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check_eq("store_abort", outs, V_NONE);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(V_NONE);
            step_check($sformatf("abort_idle_c%0d", i), 3'b010, 1'b0, 1'b0);
        end
        @(negedge clk);
        run = 1'b1;
        exp_q.push_back(V_F0);
        step_check("restart_f0", 3'b001, 1'b0, 1'b0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

    // Safety net so the bench always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
